compare_4a: RTL and testbench

- Registered magnitude comparator for two 4-bit operands (width parameterisable).
- Produces a one-hot 3-bit result: greater, equal, less.
- Used as a leaf datapath block wherever a registered compare flag set is needed.
- Operands are sampled on an enable strobe, with unsigned or two's-complement interpretation.

---
 rtl/compare_4a.sv | 54 +++++
 tb/tb_compare_4a.sv | 124 ++++++++++++
 2 files changed

// File: rtl/compare_4a.sv
// Registered magnitude comparator: captures a one-hot {gt, eq, lt} flag set
// for operands a/b on each en strobe, unsigned or two's-complement per sgn.
module compare_4a #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       y,
  output logic             y_valid
);

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] a_k, b_k;
  logic [2:0]       cmp;
  logic [2:0]       y_q, y_d;
  logic             vld_q, vld_d;

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes. Equality is unaffected.
  always_comb begin
    a_k = sgn ? (a ^ MSB_MASK) : a;
    b_k = sgn ? (b ^ MSB_MASK) : b;
  end

  always_comb begin
    cmp = 3'b010;
    if (a_k > b_k)      cmp = 3'b100;
    else if (a_k < b_k) cmp = 3'b001;
  end

  always_comb begin
    y_d   = en ? cmp : y_q;
    vld_d = en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= 3'b000;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign y       = y_q;
  assign y_valid = vld_q;

endmodule

// File: tb/tb_compare_4a.sv
// Directed + randomized bench for compare_4a against an integer-arithmetic reference.
module tb_compare_4a;
  localparam int W = 4;

  logic         clk, rst_n, en, sgn;
  logic [W-1:0] a, b;
  logic [2:0]   y;
  logic         y_valid;

  logic [2:0]   exp_y;
  logic         exp_v;
  int           n_cmp, n_err;

  compare_4a #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sgn(sgn),
    .a(a), .b(b), .y(y), .y_valid(y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as plain integers and compare.
  function automatic logic [2:0] ref_cmp(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    int ia, ib;
    ia = int'(aa);
    ib = int'(bb);
    if (s && aa[W-1]) ia = ia - (1 << W);
    if (s && bb[W-1]) ib = ib - (1 << W);
    if (ia > ib)       return 3'b100;
    else if (ia == ib) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic chk(input string tag);
    n_cmp++;
    assert (y === exp_y) else begin
      n_err++;
      $error("FAIL %s: y got %b want %b", tag, y, exp_y);
    end
    n_cmp++;
    assert (y_valid === exp_v) else begin
      n_err++;
      $error("FAIL %s: y_valid got %b want %b", tag, y_valid, exp_v);
    end
  endtask

  // Drive one cycle's inputs, advance past the edge, update model, check.
  task automatic cyc(input logic e, input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb, input string tag);
    en = e; sgn = s; a = aa; b = bb;
    @(posedge clk);
    if (rst_n) begin
      if (e) exp_y = ref_cmp(s, aa, bb);
      exp_v = e;
    end
    #1;
    chk(tag);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; en = 1'b0; sgn = 1'b0; a = '0; b = '0;
    exp_y = 3'b000; exp_v = 1'b0;
    #2;
    chk("reset_state");
    @(posedge clk); #1;
    chk("reset_hold");
    #3 rst_n = 1'b1;

    // Reset asynchronously while y=100
    cyc(1'b1, 1'b0, 4'd5, 4'd3, "pre_reset_cap");
    #2 rst_n = 1'b0;
    exp_y = 3'b000; exp_v = 1'b0;
    #1 chk("async_reset");
    cyc(1'b1, 1'b0, 4'd9, 4'd1, "reset_ignores_en");
    #3 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 4'd7, 4'd2, "release_en0");
    cyc(1'b0, 1'b1, 4'd1, 4'd9, "release_en0_b");

    // Unsigned basics, back-to-back
    cyc(1'b1, 1'b0, 4'd0,  4'd0,  "u_0_0");
    cyc(1'b1, 1'b0, 4'd5,  4'd3,  "u_5_3");
    cyc(1'b1, 1'b0, 4'd3,  4'd5,  "u_3_5");
    cyc(1'b1, 1'b0, 4'd15, 4'd15, "u_15_15");

    // Signed vs unsigned
    cyc(1'b1, 1'b0, 4'b1000, 4'b0111, "u_8_7");
    cyc(1'b1, 1'b1, 4'b1000, 4'b0111, "s_m8_7");
    cyc(1'b1, 1'b1, 4'b1111, 4'b0000, "s_m1_0");
    cyc(1'b1, 1'b1, 4'b0111, 4'b1000, "s_7_m8");

    // Hold: en=0 sweeps must not disturb y
    cyc(1'b1, 1'b0, 4'd9, 4'd2, "hold_cap");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, i[0], 4'(i * 3), 4'(15 - i * 2), "hold");
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b1, 4'(i), 4'(15 - i), "hold_sweep");

    // Exhaustive, both modes, en every cycle
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          cyc(1'b1, s[0], 4'(i), 4'(j), "exhaustive");

    // Randomized mix of captures and holds
    for (int k = 0; k < 300; k++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "random");

    // Reset mid-stream during back-to-back captures
    cyc(1'b1, 1'b0, 4'd12, 4'd4, "stream_a");
    cyc(1'b1, 1'b1, 4'd12, 4'd4, "stream_b");
    en = 1'b1; a = 4'd6; b = 4'd6;
    #2 rst_n = 1'b0;
    exp_y = 3'b000; exp_v = 1'b0;
    #1 chk("midstream_reset");
    cyc(1'b1, 1'b0, 4'd14, 4'd3, "in_reset");
    #3 rst_n = 1'b1;
    cyc(1'b1, 1'b0, 4'd1, 4'd2, "post_reset_1_2");
    cyc(1'b0, 1'b0, 4'd0, 4'd0, "post_reset_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
